exec_ctrl: RTL and testbench

Execution controller for the 8-bit single-cycle CPU. Gates every architectural state update (PC, register file, data memory) through a one-cycle `cpu_en` strobe derived from the slow `tick`, implementing RUN / single-STEP / HALT modes, a PC breakpoint, and self-loop halt detection. While halted it owns the instruction-memory write port and accepts program bytes from a loader over a valid/ready handshake. Sits between the frequency divider, the front-panel buttons and the CPU core.

---
 rtl/exec_ctrl_pkg.sv | 25 ++
 rtl/exec_ctrl_btn_debounce.sv | 37 +++
 rtl/exec_ctrl.sv | 143 ++++++++++++++
 tb/tb_exec_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/exec_ctrl_pkg.sv
// Shared types and instruction-decode constants for the execution controller.
package exec_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        HC_NONE     = 2'b00,
        HC_BUTTON   = 2'b01,
        HC_BREAK    = 2'b10,
        HC_SELFLOOP = 2'b11
    } halt_cause_t;

    localparam logic [1:0] OP_BRANCH = 2'b11;
    localparam logic [1:0] IMM_SELF  = 2'b11;

    // A branch whose offset field points back at itself never leaves its PC.
    function automatic logic is_self_loop(input logic [7:0] ins);
        return (ins[7:6] == OP_BRANCH) && (ins[1:0] == IMM_SELF);
    endfunction

endpackage

// File: rtl/exec_ctrl_btn_debounce.sv
// Button debouncer: level follows raw only after DEBOUNCE_CYCLES equal samples;
// emits a one-cycle pulse on each accepted rising edge.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic clear,
    input  logic raw,
    output logic pulse
);

    localparam int             CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (!clear) begin
            level <= 1'b0;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            pulse <= 1'b0;
            if (raw == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= raw;
                cnt   <= '0;
                pulse <= raw;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/exec_ctrl.sv
// Execution controller: paces CPU state updates off tick with RUN/STEP/HALT,
// breakpoint and self-loop halts, and owns the imem write port while halted.
module exec_ctrl
    import exec_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             tick,
    input  logic             run_btn,
    input  logic             step_btn,
    input  logic             halt_btn,
    input  logic             bp_en,
    input  logic [7:0]       bp_addr,
    input  logic [7:0]       pc,
    input  logic [7:0]       instr,
    input  logic             load_valid,
    input  logic [7:0]       load_addr,
    input  logic [7:0]       load_data,
    output logic             load_ready,
    output logic             imem_we,
    output logic [7:0]       imem_waddr,
    output logic [7:0]       imem_wdata,
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] instr_count
);

    state_t      cur_state, nxt_state;
    halt_cause_t cause_q, cause_d;
    logic        armed, armed_d, en_d;
    logic        run_p, step_p, halt_p;
    logic        bp_hit, self_loop;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
        .clock(clock), .clear(clear), .raw(run_btn), .pulse(run_p)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
        .clock(clock), .clear(clear), .raw(step_btn), .pulse(step_p)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_halt_db (
        .clock(clock), .clear(clear), .raw(halt_btn), .pulse(halt_p)
    );

    // armed suppresses the breakpoint on the first tick after resuming
    assign bp_hit    = bp_en && (pc == bp_addr) && armed;
    assign self_loop = is_self_loop(instr);

    always_ff @(posedge clock) begin
        if (!clear) begin
            cur_state <= ST_HALT;
            cause_q   <= HC_NONE;
            armed     <= 1'b0;
            cpu_en    <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            cause_q   <= cause_d;
            armed     <= armed_d;
            cpu_en    <= en_d;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            ST_HALT: begin
                if (!halt_p) begin
                    if (step_p)     nxt_state = ST_STEP;
                    else if (run_p) nxt_state = ST_RUN;
                end
            end
            ST_RUN:  if (halt_p || (tick && (bp_hit || self_loop))) nxt_state = ST_HALT;
            ST_STEP: if (halt_p || tick) nxt_state = ST_HALT;
            default: nxt_state = ST_HALT;
        endcase
    end

    always_comb begin
        en_d    = 1'b0;
        cause_d = cause_q;
        armed_d = armed;
        case (cur_state)
            ST_HALT: begin
                if (!halt_p && (step_p || run_p)) begin
                    cause_d = HC_NONE;
                    armed_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (halt_p) begin
                    cause_d = HC_BUTTON;
                end else if (tick) begin
                    if (bp_hit)         cause_d = HC_BREAK;
                    else if (self_loop) cause_d = HC_SELFLOOP;
                    else begin
                        en_d    = 1'b1;
                        armed_d = 1'b1;
                    end
                end
            end
            ST_STEP: begin
                if (halt_p) begin
                    cause_d = HC_BUTTON;
                end else if (tick) begin
                    en_d    = 1'b1;
                    armed_d = 1'b1;
                    cause_d = HC_NONE;
                end
            end
            default: ;
        endcase
    end

    assign state      = cur_state;
    assign halt_cause = cause_q;
    assign load_ready = (cur_state == ST_HALT);

    always_ff @(posedge clock) begin
        if (!clear) begin
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= load_valid && load_ready;
            if (load_valid && load_ready) begin
                imem_waddr <= load_addr;
                imem_wdata <= load_data;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            instr_count <= '0;
        end else if (cpu_en && (instr_count != '1)) begin
            instr_count <= instr_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_exec_ctrl.sv
// Self-checking bench for exec_ctrl: directed scenarios plus a random phase,
// all cycles compared against a behavioural model of the controller.
module tb_exec_ctrl;

    localparam int N    = 4;
    localparam int CW   = 5;
    localparam int CMAX = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          clear = 1'b0;
    logic          tick = 1'b0, run_btn = 1'b0, step_btn = 1'b0, halt_btn = 1'b0;
    logic          bp_en = 1'b0, load_valid = 1'b0;
    logic [7:0]    bp_addr = '0, pc = '0, instr = '0, load_addr = '0, load_data = '0;
    logic          load_ready, imem_we, cpu_en;
    logic [7:0]    imem_waddr, imem_wdata;
    logic [1:0]    state, halt_cause;
    logic [CW-1:0] instr_count;

    exec_ctrl #(.DEBOUNCE_CYCLES(N), .CNT_W(CW)) dut (
        .clock(clock), .clear(clear), .tick(tick),
        .run_btn(run_btn), .step_btn(step_btn), .halt_btn(halt_btn),
        .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .instr(instr),
        .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
        .load_ready(load_ready), .imem_we(imem_we),
        .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .cpu_en(cpu_en), .state(state), .halt_cause(halt_cause),
        .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    int n_vec = 0, n_err = 0;

    // reference model: modes 0=HALT 1=RUN 2=STEP, causes 0..3
    int         m_state, m_cause, m_cnt;
    bit         m_armed, m_en, m_we;
    logic [7:0] m_wa, m_wd;
    logic [N-1:0] m_hist [3];
    bit         m_lvl [3];
    bit         m_pls [3];
    bit         en_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit rp, sp, hp, rdy, en_n, old;
        logic [2:0] raw;
        if (!clear) begin
            m_state = 0; m_cause = 0; m_cnt = 0; m_armed = 0; m_en = 0;
            m_we = 0; m_wa = '0; m_wd = '0;
            for (int b = 0; b < 3; b++) begin
                m_hist[b] = '0; m_lvl[b] = 0; m_pls[b] = 0;
            end
            return;
        end
        rp = m_pls[0]; sp = m_pls[1]; hp = m_pls[2];
        rdy = (m_state == 0);
        if (m_en) m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
        m_we = load_valid && rdy;
        if (m_we) begin m_wa = load_addr; m_wd = load_data; end
        en_n = 0;
        case (m_state)
            0: if (!hp && (sp || rp)) begin
                m_state = sp ? 2 : 1; m_cause = 0; m_armed = 0;
            end
            1: if (hp) begin
                m_state = 0; m_cause = 1;
            end else if (tick) begin
                if (bp_en && pc == bp_addr && m_armed) begin m_state = 0; m_cause = 2; end
                else if (instr[7:6] == 2'b11 && instr[1:0] == 2'b11) begin m_state = 0; m_cause = 3; end
                else begin en_n = 1; m_armed = 1; end
            end
            default: if (hp) begin
                m_state = 0; m_cause = 1;
            end else if (tick) begin
                en_n = 1; m_armed = 1; m_state = 0; m_cause = 0;
            end
        endcase
        m_en = en_n;
        // debounced level = raw once the last N samples all agree
        raw = {halt_btn, step_btn, run_btn};
        for (int b = 0; b < 3; b++) begin
            old = m_lvl[b];
            m_hist[b] = {m_hist[b][N-2:0], raw[b]};
            if (&m_hist[b]) m_lvl[b] = 1;
            else if (m_hist[b] == '0) m_lvl[b] = 0;
            m_pls[b] = m_lvl[b] && !old;
        end
    endtask

    task automatic cyc();
        bit adv;
        adv = m_en;
        model_edge();
        @(posedge clock);
        #1;
        if (adv) pc = pc + 8'd1;
        check("state", 32'(state), m_state);
        check("halt_cause", 32'(halt_cause), m_cause);
        check("cpu_en", 32'(cpu_en), 32'(m_en));
        check("load_ready", 32'(load_ready), 32'(m_state == 0));
        check("imem_we", 32'(imem_we), 32'(m_we));
        check("imem_waddr", 32'(imem_waddr), 32'(m_wa));
        check("imem_wdata", 32'(imem_wdata), 32'(m_wd));
        check("instr_count", 32'(instr_count), m_cnt);
        if (cpu_en) en_seen = 1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic do_tick(input int n);
        repeat (n) begin
            tick = 1'b1; cyc();
            tick = 1'b0; idle(3);
        end
    endtask

    task automatic press(input logic [2:0] m, input int hold);
        {halt_btn, step_btn, run_btn} = m;
        idle(hold);
        {halt_btn, step_btn, run_btn} = 3'b000;
        idle(N + 2);
    endtask

    initial begin
        clear = 1'b0; idle(2);
        clear = 1'b1;

        // idle after reset: nothing executes
        en_seen = 0;
        do_tick(10);
        check("t1_state", 32'(state), 0);
        check("t1_count", 32'(instr_count), 0);
        check("t1_ready", 32'(load_ready), 1);
        check("t1_en_seen", 32'(en_seen), 0);

        // back-to-back program load
        load_valid = 1'b1; load_addr = 8'h00; load_data = 8'h41; cyc();
        check("t2_we0", 32'(imem_we), 1);
        check("t2_addr0", 32'(imem_waddr), 32'h00);
        check("t2_data0", 32'(imem_wdata), 32'h41);
        load_addr = 8'h01; load_data = 8'h82; cyc();
        check("t2_we1", 32'(imem_we), 1);
        check("t2_addr1", 32'(imem_waddr), 32'h01);
        check("t2_data1", 32'(imem_wdata), 32'h82);
        load_valid = 1'b0; cyc();
        check("t2_we_off", 32'(imem_we), 0);
        press(3'b001, N);
        check("t2_ready_run", 32'(load_ready), 0);
        check("t2_state_run", 32'(state), 1);

        // free run, then halt button
        do_tick(5);
        check("t3_count", 32'(instr_count), 5);
        press(3'b100, N);
        check("t3_state", 32'(state), 0);
        check("t3_cause", 32'(halt_cause), 1);

        // breakpoint at 3, then resume through it
        pc = 8'h00; bp_en = 1'b1; bp_addr = 8'h03;
        press(3'b001, N);
        do_tick(4);
        check("t4_state", 32'(state), 0);
        check("t4_cause", 32'(halt_cause), 2);
        check("t4_count", 32'(instr_count), 8);
        press(3'b001, N);
        do_tick(2);
        check("t4_resume_state", 32'(state), 1);
        check("t4_resume_count", 32'(instr_count), 10);
        bp_en = 1'b0;

        // self-loop halt, then a single step over it
        instr = 8'hC3;
        do_tick(1);
        check("t5_state", 32'(state), 0);
        check("t5_cause", 32'(halt_cause), 3);
        check("t5_count", 32'(instr_count), 10);
        press(3'b010, N);
        check("t5_step_state", 32'(state), 2);
        do_tick(1);
        check("t5_after_step", 32'(state), 0);
        check("t5_step_count", 32'(instr_count), 11);
        instr = 8'h00;

        // bouncing step button: one step only
        step_btn = 1'b1; idle(2);
        step_btn = 1'b0; idle(1);
        step_btn = 1'b1; idle(4);
        step_btn = 1'b0; idle(N + 2);
        check("t6_bounce_state", 32'(state), 2);
        do_tick(2);
        check("t6_bounce_count", 32'(instr_count), 12);
        check("t6_bounce_halt", 32'(state), 0);

        // halt and run together: halt wins
        press(3'b101, N);
        check("t6_prio_state", 32'(state), 0);

        // counter saturation
        press(3'b001, N);
        do_tick(25);
        check("t7_sat", 32'(instr_count), CMAX);
        press(3'b100, N);

        // random phase
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0)  run_btn  = ~run_btn;
            if ($urandom_range(0, 11) == 0) step_btn = ~step_btn;
            if ($urandom_range(0, 19) == 0) halt_btn = ~halt_btn;
            tick       = ($urandom_range(0, 3) == 0);
            bp_en      = 1'($urandom_range(0, 1));
            bp_addr    = 8'($urandom_range(0, 7));
            instr      = ($urandom_range(0, 9) == 0) ? 8'hC3 : 8'($urandom);
            if ($urandom_range(0, 7) == 0) pc = 8'($urandom_range(0, 7));
            load_valid = 1'($urandom_range(0, 1));
            load_addr  = 8'($urandom);
            load_data  = 8'($urandom);
            clear      = ($urandom_range(0, 299) != 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
